// File: rtl/sram_buf_pipe.sv
// Simple-dual-port tile buffer with programmable read latency and EMPTY/LOADING/LOADED load tracking.
// Define SRAM_PARITY_EN to store an even-parity bit per word and flag mismatches on read.
module sram_buf_pipe #(
   parameter int WORD_AMOUNT  = 3136,
   parameter int BIT_PER_WORD = 145,
   parameter int RD_LAT       = 1,
   localparam int ADDR_W      = $clog2(WORD_AMOUNT)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we,
   input  logic [ADDR_W-1:0]       waddr,
   input  logic [BIT_PER_WORD-1:0] din,
   input  logic                    final_flag,
   input  logic                    re,
   input  logic [ADDR_W-1:0]       raddr,
   output logic [BIT_PER_WORD-1:0] dout,
   output logic                    dout_valid,
   output logic                    loaded,
   output logic [ADDR_W:0]         wr_count,
   output logic                    addr_err,
   output logic                    parity_err
);

`ifdef SRAM_PARITY_EN
   localparam int MEM_W = BIT_PER_WORD + 1;
`else
   localparam int MEM_W = BIT_PER_WORD;
`endif
   localparam logic [ADDR_W:0] WORD_AMT_C = (ADDR_W+1)'(WORD_AMOUNT);

   typedef enum logic [1:0] {S_EMPTY, S_LOADING, S_LOADED} state_t;

   state_t                 state;
   logic [MEM_W-1:0]       mem [WORD_AMOUNT];
   logic [MEM_W-1:0]       wr_word;
   logic [MEM_W-1:0]       rd_data_p [RD_LAT];
   logic [RD_LAT-1:0]      rd_vld_p;
   logic                   waddr_ok;
   logic                   raddr_ok;
   logic                   wr_reload;
   logic                   wr_accept;

   assign waddr_ok  = {1'b0, waddr} < WORD_AMT_C;
   assign raddr_ok  = {1'b0, raddr} < WORD_AMT_C;
   // In LOADED only a non-final write to word 0 gets through; it restarts the load.
   assign wr_reload = (state == S_LOADED) && (waddr == '0) && !final_flag;
   assign wr_accept = we && waddr_ok && ((state != S_LOADED) || wr_reload);

`ifdef SRAM_PARITY_EN
   function automatic logic even_par(input logic [BIT_PER_WORD-1:0] d);
      return ^d;
   endfunction
   assign wr_word = {even_par(din), din};
`else
   assign wr_word = din;
`endif

   always_ff @(posedge clk) begin
      if (wr_accept && !rst) mem[waddr] <= wr_word;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_EMPTY;
         loaded   <= 1'b0;
         wr_count <= '0;
         addr_err <= 1'b0;
      end else begin
         if ((we && !waddr_ok) || (re && !raddr_ok)) addr_err <= 1'b1;
         if (wr_accept) begin
            if (wr_reload) begin
               wr_count <= (ADDR_W+1)'(1);
               state    <= S_LOADING;
               loaded   <= 1'b0;
            end else begin
               if (wr_count != WORD_AMT_C) wr_count <= wr_count + (ADDR_W+1)'(1);
               if (final_flag) begin
                  state  <= S_LOADED;
                  loaded <= 1'b1;
               end else begin
                  state  <= S_LOADING;
               end
            end
         end
      end
   end

   // Read pipeline: stage 0 is the synchronous array read, the last stage is dout.
   // Stages only load when a valid read enters them, so dout holds between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld_p              <= '0;
         rd_data_p[RD_LAT-1]   <= '0;
      end else begin
         rd_vld_p[0] <= re;
         if (re) rd_data_p[0] <= raddr_ok ? mem[raddr] : '0;
         for (int i = 1; i < RD_LAT; i++) begin
            rd_vld_p[i] <= rd_vld_p[i-1];
            if (rd_vld_p[i-1]) rd_data_p[i] <= rd_data_p[i-1];
         end
      end
   end

   assign dout       = rd_data_p[RD_LAT-1][BIT_PER_WORD-1:0];
   assign dout_valid = rd_vld_p[RD_LAT-1];

`ifdef SRAM_PARITY_EN
   logic par_now;
   logic par_sticky;

   // Combinational term makes the flag visible alongside dout_valid; the sticky bit keeps it.
   assign par_now = rd_vld_p[RD_LAT-1] && (^rd_data_p[RD_LAT-1]);

   always_ff @(posedge clk) begin
      if (rst) par_sticky <= 1'b0;
      else if (par_now) par_sticky <= 1'b1;
   end

   assign parity_err = par_sticky || par_now;
`else
   assign parity_err = 1'b0;
`endif

endmodule
